// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU output path: FSM states, default widths
// and the int8 saturation bounds used by the requantizer.
package tpu_pkg;

    localparam int ACC_WIDTH = 24;
    localparam int DATA_SIZE = 8;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/requant_lane.sv
// One output channel of the requantizer: S1 registers acc*scale, S2 registers the
// rounded, shifted, zero-point-offset value saturated to int8.
module requant_lane
    import tpu_pkg::*;
#(
    parameter int accWidth   = ACC_WIDTH,
    parameter int dataSize   = DATA_SIZE,
    parameter int scaleWidth = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic signed [accWidth-1:0] acc,
    input  logic [scaleWidth-1:0]      scale,
    input  logic [4:0]                 shift,
    input  logic signed [dataSize-1:0] zp,
    output logic [dataSize-1:0]        q
);

    localparam int PW = accWidth + scaleWidth + 1;
    localparam int SW = PW + 1;
    localparam int QW = SW + 1;
    localparam logic signed [QW-1:0] Q_MAX = QW'(SAT_MAX);
    localparam logic signed [QW-1:0] Q_MIN = QW'(SAT_MIN);

    logic signed [PW-1:0]   p_next;
    logic signed [PW-1:0]   p_q;
    logic [SW-1:0]          rnd;
    logic signed [SW-1:0]   sum;
    logic signed [SW-1:0]   r;
    logic signed [QW-1:0]   q_wide;
    logic [dataSize-1:0]    q_next;

    // One guard bit for the rounding add, one more for the zero-point add.
    always_comb begin
        p_next = PW'(acc) * $signed(PW'(scale));
        rnd    = (shift == 5'd0) ? '0 : (SW'(1) << (shift - 5'd1));
        sum    = SW'(p_q) + $signed(rnd);
        r      = sum >>> shift;
        q_wide = QW'(r) + QW'(zp);
        // NOTE: every path below assigns q_next, so no latch is inferred.
        if (q_wide > Q_MAX) begin
            q_next = dataSize'(SAT_MAX);
        end else if (q_wide < Q_MIN) begin
            q_next = dataSize'(SAT_MIN);
        end else begin
            q_next = q_wide[dataSize-1:0];
        end
    end

    // NOTE: non-blocking assignments so both stages update from pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            p_q <= '0;
            q   <= '0;
        end else begin
            p_q <= p_next;
            q   <= q_next;
        end
    end

endmodule

// File: rtl/ofmap_writeback.sv
// Output writeback: requantizes accumulator vectors to int8, buffers them in a small
// FIFO and serializes lanes into consecutive unified-buffer writes.
module ofmap_writeback
    import tpu_pkg::*;
#(
    parameter int numOutChannel = 3,
    parameter int accWidth      = ACC_WIDTH,
    parameter int dataSize      = DATA_SIZE,
    parameter int numAddrBuffer = 8,
    parameter int scaleWidth    = 16,
    parameter int fifoDepth     = 4
) (
    input  logic                                          clk,
    input  logic                                          nrst,
    input  logic                                          ctrl_start,
    input  logic [numAddrBuffer-1:0]                      cfg_base_addr,
    input  logic [15:0]                                   cfg_num_pixels,
    input  logic [scaleWidth-1:0]                         cfg_scale,
    input  logic [4:0]                                    cfg_shift,
    input  logic signed [dataSize-1:0]                    cfg_zero_point,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic signed [numOutChannel-1:0][accWidth-1:0] in_data,
    input  logic                                          wr_ready,
    output logic                                          wr_en,
    output logic [numAddrBuffer-1:0]                      wr_addr,
    output logic [dataSize-1:0]                           wr_data,
    output logic                                          flag_busy,
    output logic                                          flag_done
);

    localparam int PTR_W  = $clog2(fifoDepth);
    localparam int CNT_W  = PTR_W + 1;
    localparam int OCC_W  = CNT_W + 1;
    localparam int LANE_W = (numOutChannel > 1) ? $clog2(numOutChannel) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(numOutChannel - 1);

    typedef logic [numOutChannel-1:0][dataSize-1:0] vec_t;

    state_t                     state;
    state_t                     state_next;
    logic [15:0]                num_pix_q;
    logic [15:0]                acc_cnt;
    logic [15:0]                pix_done_cnt;
    logic [scaleWidth-1:0]      scale_q;
    logic [4:0]                 shift_q;
    logic signed [dataSize-1:0] zp_q;
    logic                       s1_valid;
    logic                       s2_valid;
    vec_t                       s2_data;
    vec_t                       fifo_mem [fifoDepth];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           fifo_count;
    logic [OCC_W-1:0]           occupancy;
    logic [LANE_W-1:0]          lane_idx;
    logic [numAddrBuffer-1:0]   next_addr;
    logic                       wr_last;
    logic                       start;
    logic                       accept;
    logic                       push;
    logic                       pop;
    logic                       load;
    logic                       wr_fire;
    logic                       run_last;

    // Slots already promised to S1/S2 count against FIFO space, so S2 can always push.
    assign start     = (state == ST_IDLE) && ctrl_start;
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(s1_valid) + OCC_W'(s2_valid);
    assign in_ready  = (state == ST_RUN) && (occupancy < OCC_W'(fifoDepth))
                       && (acc_cnt != num_pix_q);
    assign accept    = in_valid && in_ready;
    assign push      = s2_valid;
    assign wr_fire   = wr_en && wr_ready;
    assign load      = (state == ST_RUN) && (fifo_count != '0) && (!wr_en || wr_ready);
    assign pop       = load && (lane_idx == LAST_LANE);
    assign run_last  = wr_fire && wr_last && (pix_done_cnt == num_pix_q - 16'd1);

    for (genvar i = 0; i < numOutChannel; i++) begin : g_lane
        requant_lane #(
            .accWidth   (accWidth),
            .dataSize   (dataSize),
            .scaleWidth (scaleWidth)
        ) u_lane (
            .clk   (clk),
            .nrst  (nrst),
            .acc   (in_data[i]),
            .scale (scale_q),
            .shift (shift_q),
            .zp    (zp_q),
            .q     (s2_data[i])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ctrl_start) state_next = ST_RUN;
            ST_RUN:  if ((num_pix_q == 16'd0) || run_last) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        flag_busy = (state == ST_RUN);
        flag_done = (state == ST_DONE);
    end

    // NOTE: FIFO storage has no reset; pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= s2_data;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            num_pix_q    <= '0;
            scale_q      <= '0;
            shift_q      <= '0;
            zp_q         <= '0;
            acc_cnt      <= '0;
            pix_done_cnt <= '0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            lane_idx     <= '0;
            next_addr    <= '0;
            wr_last      <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else if (start) begin
            num_pix_q    <= cfg_num_pixels;
            scale_q      <= cfg_scale;
            shift_q      <= cfg_shift;
            zp_q         <= cfg_zero_point;
            acc_cnt      <= '0;
            pix_done_cnt <= '0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            lane_idx     <= '0;
            next_addr    <= cfg_base_addr;
            wr_last      <= 1'b0;
            wr_en        <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (accept) acc_cnt <= acc_cnt + 16'd1;
            if (push)   wr_ptr  <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr  <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            // The head vector is popped as its last lane moves into the output register.
            if (load) begin
                wr_en     <= 1'b1;
                wr_addr   <= next_addr;
                wr_data   <= fifo_mem[rd_ptr][lane_idx];
                wr_last   <= (lane_idx == LAST_LANE);
                next_addr <= next_addr + numAddrBuffer'(1);
                lane_idx  <= pop ? '0 : lane_idx + LANE_W'(1);
            end else if (wr_ready) begin
                wr_en <= 1'b0;
            end
            if (wr_fire && wr_last) pix_done_cnt <= pix_done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ofmap_writeback.sv
// Directed bench for ofmap_writeback: expected writes are queued as vectors are driven
// and compared in order as the DUT completes each write.
module tb_ofmap_writeback;

    logic                    clk = 1'b0;
    logic                    nrst = 1'b1;
    logic                    ctrl_start = 1'b0;
    logic [7:0]              cfg_base_addr = '0;
    logic [15:0]             cfg_num_pixels = '0;
    logic [15:0]             cfg_scale = '0;
    logic [4:0]              cfg_shift = '0;
    logic signed [7:0]       cfg_zero_point = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [2:0][23:0] in_data = '0;
    logic                    wr_ready = 1'b1;
    logic                    wr_en;
    logic [7:0]              wr_addr;
    logic [7:0]              wr_data;
    logic                    flag_busy;
    logic                    flag_done;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        sb[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         cyc = 0;
    int         writes_seen = 0;
    int         first_wr_cyc = -1;
    int         last_wr_cyc = -1;
    int         accept_cyc = 0;
    int         start_cyc = 0;
    logic [7:0] exp_addr = '0;
    bit         saw_stall = 1'b0;

    ofmap_writeback dut (
        .clk            (clk),
        .nrst           (nrst),
        .ctrl_start     (ctrl_start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_num_pixels (cfg_num_pixels),
        .cfg_scale      (cfg_scale),
        .cfg_shift      (cfg_shift),
        .cfg_zero_point (cfg_zero_point),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .wr_ready       (wr_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .flag_busy      (flag_busy),
        .flag_done      (flag_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    function automatic logic [7:0] model(input int acc, input int scale, input int shift, input int zp);
        longint p;
        longint r;
        longint q;
        p = longint'(acc) * longint'(scale);
        if (shift == 0) r = p;
        else            r = (p + (64'sd1 <<< (shift - 1))) >>> shift;
        q = r + longint'(zp);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    // Write monitor: a write completes at the next rising edge when wr_en & wr_ready.
    always @(negedge clk) begin
        if (nrst) begin
            if (flag_busy && in_valid && !in_ready) saw_stall = 1'b1;
            if (wr_en && !wr_ready) begin
                if (sb.size() > 0) begin
                    check("hold_addr", wr_addr, sb[0].addr);
                    check("hold_data", wr_data, sb[0].data);
                end else begin
                    check("hold_unexpected", sb.size(), 1);
                end
            end
            if (wr_en && wr_ready) begin
                writes_seen++;
                last_wr_cyc = cyc;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                if (sb.size() > 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                end else begin
                    check("extra_write", sb.size(), 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] base, input logic [15:0] n, input logic [15:0] scale,
                            input logic [4:0] shift, input logic signed [7:0] zp);
        cfg_base_addr  = base;
        cfg_num_pixels = n;
        cfg_scale      = scale;
        cfg_shift      = shift;
        cfg_zero_point = zp;
        ctrl_start     = 1'b1;
        exp_addr       = base;
        tick();
        start_cyc      = cyc;
        ctrl_start     = 1'b0;
        // Scramble cfg so only the latched copy can produce correct results.
        cfg_base_addr  = ~base;
        cfg_num_pixels = n + 16'd5;
        cfg_scale      = ~scale;
        cfg_shift      = ~shift;
        cfg_zero_point = ~zp;
        check("busy_after_start", flag_busy, 1);
    endtask

    task automatic push_exp(input logic [7:0] d);
        wr_t e;
        e.addr = exp_addr;
        e.data = d;
        sb.push_back(e);
        exp_addr = exp_addr + 8'd1;
    endtask

    task automatic send_vec(input int a0, input int a1, input int a2,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        bit ok;
        push_exp(e0);
        push_exp(e1);
        push_exp(e2);
        in_data[0] = 24'(a0);
        in_data[1] = 24'(a1);
        in_data[2] = 24'(a2);
        in_valid   = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("in_ready_timeout", ok, 1);
        tick();
        accept_cyc = cyc;
        in_valid   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit zero_len);
        bit seen;
        int exp_cyc;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (flag_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            exp_cyc = zero_len ? start_cyc + 1 : last_wr_cyc + 1;
            check({tag, "_done_cycle"}, cyc, exp_cyc);
            check({tag, "_busy_in_done"}, flag_busy, 0);
            check({tag, "_wr_en_in_done"}, wr_en, 0);
        end
        check({tag, "_sb_drained"}, sb.size(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, flag_done, 0);
    endtask

    initial begin
        int ws0;
        bit hit;
        #2 nrst = 1'b0;
        #10;
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", flag_busy, 0);
        check("rst_done", flag_done, 0);
        tick();
        nrst = 1'b1;
        tick();

        // Passthrough and minimum latency
        first_wr_cyc = -1;
        do_start(8'd16, 16'd1, 16'd1, 5'd0, 8'sd0);
        send_vec(5, -3, 127, 8'h05, 8'hFD, 8'h7F);
        wait_done("pass", 1'b0);
        check("latency", first_wr_cyc - accept_cyc, 3);

        // Saturation
        do_start(8'd32, 16'd1, 16'd1, 5'd0, 8'sd0);
        send_vec(1000, -1000, 0, 8'h7F, 8'h80, 8'h00);
        wait_done("sat", 1'b0);

        // Rounding shift with zero point
        do_start(8'd48, 16'd1, 16'd3, 5'd2, 8'sd10);
        send_vec(3, -3, 2, 8'd12, 8'd8, 8'd12);
        wait_done("round", 1'b0);

        // Backpressure: nine pixels streamed while the buffer stalls
        ws0 = writes_seen;
        saw_stall = 1'b0;
        do_start(8'd100, 16'd9, 16'd5, 5'd3, -8'sd4);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 wr_ready = 1'b0;
                repeat (9) @(posedge clk);
                #1 wr_ready = 1'b1;
            end
        join_none
        for (int p = 0; p < 9; p++) begin
            int a0, a1, a2;
            a0 = int'($urandom_range(600)) - 300;
            a1 = int'($urandom_range(600)) - 300;
            a2 = (p == 4) ? 8000 : int'($urandom_range(600)) - 300;
            send_vec(a0, a1, a2, model(a0, 5, 3, -4), model(a1, 5, 3, -4), model(a2, 5, 3, -4));
        end
        wait_done("bp", 1'b0);
        check("bp_write_count", writes_seen - ws0, 27);
        check("bp_in_ready_dropped", saw_stall, 1);

        // Address wrap
        do_start(8'd254, 16'd1, 16'd1, 5'd0, 8'sd0);
        send_vec(1, 2, 3, 8'd1, 8'd2, 8'd3);
        wait_done("wrap", 1'b0);

        // Zero-length run
        ws0 = writes_seen;
        do_start(8'd0, 16'd0, 16'd1, 5'd0, 8'sd0);
        wait_done("zero", 1'b1);
        check("zero_no_writes", writes_seen - ws0, 0);

        // Reset in the middle of a run
        ws0 = writes_seen;
        do_start(8'd40, 16'd3, 16'd1, 5'd0, 8'sd0);
        send_vec(10, 11, 12, 8'd10, 8'd11, 8'd12);
        send_vec(13, 14, 15, 8'd13, 8'd14, 8'd15);
        send_vec(16, 17, 18, 8'd16, 8'd17, 8'd18);
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (writes_seen - ws0 >= 4) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("mid_writes_before_reset", writes_seen - ws0, 4);
        check("mid_reached", hit, 1);
        nrst = 1'b0;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_busy", flag_busy, 0);
        check("mid_rst_done", flag_done, 0);
        check("mid_rst_in_ready", in_ready, 0);
        sb.delete();
        tick();
        nrst = 1'b1;
        tick();
        tick();
        check("after_rst_idle", flag_busy, 0);
        do_start(8'd40, 16'd1, 16'd1, 5'd0, 8'sd0);
        send_vec(7, 8, 9, 8'd7, 8'd8, 8'd9);
        wait_done("rerun", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/ofmap_writeback.md
# ofmap_writeback

Output-side stage of `tpu_system`. It sits directly downstream of the systolic array's `matrix_out` vector and upstream of the `buffer_router` unified-buffer write port. It accepts one signed accumulator vector per output pixel (one lane per output channel), requantizes each lane to int8 (scale, rounding shift, zero point, saturate), and serializes the lanes into consecutive unified-buffer writes starting at the ofmap base address. A completion pulse is raised once the configured pixel count has been written.

## Interface
- `numOutChannel`, 3, lanes per input vector (= nPEx)
- `accWidth`, 24, signed accumulator width per lane
- `dataSize`, 8, output element width (signed int8)
- `numAddrBuffer`, 8, unified-buffer address width
- `scaleWidth`, 16, unsigned requant multiplier width
- `fifoDepth`, 4, vector FIFO entries (power of 2, ≥2)

Ports:
- `clk`  in  1  clock, rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `ctrl_start`  in  1  one-cycle pulse; latches cfg and starts a run.
- `cfg_base_addr`  in  numAddrBuffer  first ofmap address.
- `cfg_num_pixels`  in  16  vectors to write this run.
- `cfg_scale`  in  scaleWidth  multiplier, unsigned.
- `cfg_shift`  in  5  right shift, 0..31.
- `cfg_zero_point`  in  dataSize  signed offset added after the shift.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  vector accepted on `in_valid & in_ready`.
- `in_data`  in  [numOutChannel][accWidth] signed  accumulator vector.
- `wr_ready`  in  1  buffer accepts write this cycle.
- `wr_en`  out  1  write strobe.
- `wr_addr`  out  numAddrBuffer  write address.
- `wr_data`  out  dataSize  requantized element.
- `flag_busy`  out  1  run in progress.
- `flag_done`  out  1  one-cycle pulse at run end.

## Operation
- FSM `IDLE → RUN → DONE → IDLE`.
- `IDLE`: `in_ready`=0. `in_valid` is ignored. `ctrl_start` latches all cfg, clears pixel and channel counters, and moves to `RUN`.
- `RUN`: `flag_busy`=1. `ctrl_start` is ignored.
- When all `cfg_num_pixels` vectors have been written, the FSM moves to `DONE`. `DONE` lasts one cycle: `flag_done`=1, `flag_busy`=0, then the FSM returns to `IDLE`.
- `cfg_num_pixels`=0: the FSM goes `RUN` for one cycle, then `DONE`. No writes are issued.
- Requant per lane:
  - p = acc × scale, signed, accWidth+scaleWidth+1 bits.
  - If shift>0: r = (p + 2^(shift−1)) >>> shift. If shift=0: r = p.
  - q = r + sign-extended zero point.
  - Saturate q to [−128, 127].
- Pipeline: S1 registers p for all lanes. S2 registers saturated q and pushes the vector into the FIFO.
- Serializer pops the FIFO head and emits lanes 0..numOutChannel−1, one per cycle while `wr_ready`=1.
- Addressing: address = base + pixel·numOutChannel + lane, modulo 2^numAddrBuffer (wraps 255→0).
- Flow control: in_ready = RUN & (fifo_count + inflight < fifoDepth), where inflight counts occupied S1/S2 slots. No vector is ever dropped.
- Vectors accepted beyond `cfg_num_pixels` are not accepted: `in_ready`=0 once the accepted count equals `cfg_num_pixels`.

## Timing
- Reset values: FSM=`IDLE`; `in_ready`, `wr_en`, `flag_busy`, `flag_done`=0; `wr_addr`, `wr_data`=0; FIFO empty; counters 0.
- `ctrl_start` sampled at edge T → `flag_busy`=1 and `in_ready` may be 1 after T.
- Vector accepted at edge N → S1 at N+1 → FIFO push at N+2 → first `wr_en` registered high after edge N+3 (minimum latency 3 cycles).
- `wr_en`/`wr_addr`/`wr_data` hold stable while `wr_ready`=0. A write completes at an edge where `wr_en & wr_ready`.
- Last write completes at edge L → `flag_done` is high for the cycle after L.
- Push and pop in the same cycle are legal. Count is unchanged when the FIFO is full with a simultaneous pop.
- `nrst` low mid-run: immediately return to reset values. Pipeline and FIFO contents are discarded. The run does not resume.

## Structure
- Shared package `tpu_pkg`: FSM state enum, the requant saturation bounds, and `accWidth`/`dataSize` defaults.
- One sub-module, `requant_lane`: a 2-stage multiply/round/saturate pipeline instantiated numOutChannel times.
- FIFO and serializer stay inline.

## Test plan
- Passthrough: scale=1, shift=0, zp=0, base=16, 1 pixel, acc=(5, −3, 127) → writes (16:0x05), (17:0xFD), (18:0x7F); then `flag_done` pulse.
- Saturation: acc=(1000, −1000, 0), scale=1, shift=0, zp=0 → 0x7F, 0x80, 0x00.
- Rounding: scale=3, shift=2, zp=10, acc=(3, −3, 2) → 12, 8, 12 (9+2>>2=2; −9+2>>>2=−2; 6+2>>2=2).
- Backpressure: 9 pixels streamed back-to-back, `wr_ready` low cycles 4–12 → `in_ready` drops, 27 writes in order with correct addresses, none lost or duplicated.
- Wrap and zero-length: base=254, 1 pixel → addresses 254, 255, 0. Then `cfg_num_pixels`=0 → no `wr_en`, `flag_done` 2 cycles after `ctrl_start`.
- Reset mid-run: assert `nrst` after 4 writes → all outputs 0 and state `IDLE` immediately; next `ctrl_start` run writes from base.
